// File: rtl/quad2pos.sv
// quad2pos: quadrature stream to bounded absolute position (sync, glitch filter, x4 decode).
// Define QUAD2POS_WRAP_EN to make the position wrap instead of saturating.
module quad2pos #(
  parameter int POS_W    = 8,
  parameter int POS_MIN  = 0,
  parameter int POS_MAX  = 255,
  parameter int POS_INIT = 128,
  parameter int FILT_LEN = 3
) (
  input  logic             CLK,
  input  logic             reset_n,
  input  logic [1:0]       quad,
  input  logic             center,
  output logic [POS_W-1:0] pos,
  output logic             step_pulse,
  output logic             dir,
  output logic             err
);
  localparam logic [POS_W-1:0] L_MIN  = POS_W'(POS_MIN);
  localparam logic [POS_W-1:0] L_MAX  = POS_W'(POS_MAX);
  localparam logic [POS_W-1:0] L_INIT = POS_W'(POS_INIT);
  logic [1:0]       r_s1, r_s2, r_f;
  logic [3:0]       r_cnt;
  logic             w_load, w_inc, w_dec, w_bad, w_step;
  logic [3:0]       w_tr;
  logic [POS_W-1:0] w_pos_up, w_pos_dn;
  assign w_load = (r_s2 != r_f) && (r_cnt >= 4'(FILT_LEN));
  assign w_tr   = {r_f, r_s2};
  assign w_inc  = w_load && (w_tr == 4'b0010 || w_tr == 4'b1011 || w_tr == 4'b1101 || w_tr == 4'b0100);
  assign w_dec  = w_load && (w_tr == 4'b0001 || w_tr == 4'b0111 || w_tr == 4'b1110 || w_tr == 4'b1000);
  assign w_bad  = w_load && ((r_f ^ r_s2) == 2'b11);
  assign w_step = (w_inc || w_dec) && !center;
`ifdef QUAD2POS_WRAP_EN
  assign w_pos_up = (pos == L_MAX) ? L_MIN : pos + 1'b1;
  assign w_pos_dn = (pos == L_MIN) ? L_MAX : pos - 1'b1;
`else
  assign w_pos_up = (pos == L_MAX) ? L_MAX : pos + 1'b1;
  assign w_pos_dn = (pos == L_MIN) ? L_MIN : pos - 1'b1;
`endif
  // r_cnt counts full cycles s2 has held its value; restarts on the edge s2 changes
  always_ff @(posedge CLK) begin
    if (!reset_n) begin
      r_s1       <= '0;
      r_s2       <= '0;
      r_f        <= '0;
      r_cnt      <= '0;
      pos        <= L_INIT;
      step_pulse <= 1'b0;
      dir        <= 1'b0;
      err        <= 1'b0;
    end else begin
      r_s1       <= quad;
      r_s2       <= r_s1;
      r_cnt      <= (r_s1 != r_s2) ? 4'd0 : (r_cnt == 4'hf) ? r_cnt : r_cnt + 1'b1;
      r_f        <= w_load ? r_s2 : r_f;
      err        <= w_bad;
      step_pulse <= w_step;
      dir        <= w_step ? w_inc : dir;
      pos        <= center ? L_INIT : w_inc ? w_pos_up : w_dec ? w_pos_dn : pos;
    end
  end
endmodule
